// File: rtl/arith_pkg.sv
// Shared arithmetic package: subtractor FSM state encoding, default operand
// width and a compile-time ceiling-log2 helper for sizing bit counters.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_e;

  localparam int unsigned SUB_DEFAULT_WIDTH = 8;

  // Smallest r with 2**r >= value; used only on elaboration-time constants.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle for the serial subtractor.
//   start, a, b                   : request side, driven by the master
//   busy, done, diff, borrow_out  : status/result side, driven by the slave
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );
endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, bout = borrow out.
//   x, y : operand bits      bin  : borrow in
//   d    : difference bit    bout : borrow out
// Built from two half-subtractor stages and an OR, like the full adder.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic d1;
  logic b1;
  logic b2;

  // First stage: x - y
  assign d1 = x ^ y;
  assign b1 = ~x & y;

  // Second stage: (x - y) - bin
  assign d  = d1 ^ bin;
  assign b2 = ~d1 & bin;

  // The two stage borrows can never both be set.
  assign bout = b1 | b2;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b (mod 2**WIDTH), LSB first, one bit per clock.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : start/a/b request in; busy/done/diff/borrow_out out (all registered)
// Start is accepted in IDLE or DONE; result appears WIDTH edges after acceptance.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_DEFAULT_WIDTH
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);
  localparam int unsigned CW = clog2(WIDTH);

  sub_state_e       state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] res_q;
  logic [CW-1:0]    count_q;
  logic             borrow_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_out_q;

  logic bit_d;
  logic bit_bout;

  full_subtractor u_cell (
    .x    (sa_q[0]),
    .y    (sb_q[0]),
    .bin  (borrow_q),
    .d    (bit_d),
    .bout (bit_bout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sa_q         <= '0;
      sb_q         <= '0;
      res_q        <= '0;
      count_q      <= '0;
      borrow_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            sa_q     <= bus.a;
            sb_q     <= bus.b;
            borrow_q <= 1'b0;
            count_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          sa_q     <= sa_q >> 1;
          sb_q     <= sb_q >> 1;
          res_q    <= {bit_d, res_q[WIDTH-1:1]};
          borrow_q <= bit_bout;
          count_q  <= count_q + 1'b1;
          if (count_q == CW'(WIDTH - 1)) begin
            // Last bit: publish the word including this cycle's difference bit.
            diff_q       <= {bit_d, res_q[WIDTH-1:1]};
            borrow_out_q <= bit_bout;
            done_q       <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_out_q;
endmodule
